// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave that turns each write or read into one access on the simple register bus.
// Optional aligned-address range check against MAX_ADDR: define AXIL_REG_BRIDGE_ADDR_CHECK_EN.
module axil_reg_bridge #(
    parameter int          AXI_ADDR_W = 32,
    parameter logic [31:0] MAX_ADDR   = 32'h40
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [AXI_ADDR_W-1:0] s_axil_awaddr,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [31:0]           s_axil_wdata,
    input  logic [3:0]            s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [AXI_ADDR_W-1:0] s_axil_araddr,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [31:0]           s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic                  reg_wen,
    output logic [31:0]           reg_addr,
    output logic [31:0]           reg_wdata,
    input  logic [31:0]           reg_rdata
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXIL_REG_BRIDGE_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        WR_EXEC,
        WR_RESP,
        RD_WAIT,
        RD_RESP
    } state_t;

    state_t      state_reg, state_next;
    logic        prio_rd_reg, prio_rd_next;
    logic        acc_ok_reg, acc_ok_next;
    logic        reg_wen_reg, reg_wen_next;
    logic [31:0] reg_addr_reg, reg_addr_next;
    logic [31:0] reg_wdata_reg, reg_wdata_next;
    logic        bvalid_reg, bvalid_next;
    logic [1:0]  bresp_reg, bresp_next;
    logic        rvalid_reg, rvalid_next;
    logic [1:0]  rresp_reg, rresp_next;
    logic [31:0] rdata_reg, rdata_next;

    logic [31:0] aw_addr32;
    logic [31:0] ar_addr32;
    logic [31:0] aw_aligned;
    logic [31:0] ar_aligned;
    logic        aw_in_range;
    logic        ar_in_range;
    logic        wr_ok;
    logic        write_req;
    logic        read_req;
    logic        grant_wr;
    logic        grant_rd;

    // Map the AXI address onto the 32-bit register bus: truncate wide, zero-extend narrow.
    generate
        if (AXI_ADDR_W >= 32) begin : g_addr_trunc
            assign aw_addr32 = s_axil_awaddr[31:0];
            assign ar_addr32 = s_axil_araddr[31:0];
        end else begin : g_addr_ext
            assign aw_addr32 = {{(32-AXI_ADDR_W){1'b0}}, s_axil_awaddr};
            assign ar_addr32 = {{(32-AXI_ADDR_W){1'b0}}, s_axil_araddr};
        end
    endgenerate

    assign aw_aligned  = aw_addr32 & 32'hFFFF_FFFC;
    assign ar_aligned  = ar_addr32 & 32'hFFFF_FFFC;
    assign aw_in_range = !ADDR_CHECK || (aw_aligned <= MAX_ADDR);
    assign ar_in_range = !ADDR_CHECK || (ar_aligned <= MAX_ADDR);
    assign wr_ok       = (s_axil_wstrb == 4'hF) && aw_in_range;

    // Arbitration: a lone request wins; a collision goes to whichever side the flag favours.
    always_comb begin
        write_req = s_axil_awvalid & s_axil_wvalid;
        read_req  = s_axil_arvalid;
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        if (state_reg == IDLE) begin
            if (write_req && (!read_req || !prio_rd_reg)) begin
                grant_wr = 1'b1;
            end else if (read_req) begin
                grant_rd = 1'b1;
            end
        end
    end

    assign s_axil_awready = grant_wr;
    assign s_axil_wready  = grant_wr;
    assign s_axil_arready = grant_rd;

    always_comb begin
        state_next     = state_reg;
        prio_rd_next   = prio_rd_reg;
        acc_ok_next    = acc_ok_reg;
        reg_wen_next   = reg_wen_reg;
        reg_addr_next  = reg_addr_reg;
        reg_wdata_next = reg_wdata_reg;
        bvalid_next    = bvalid_reg;
        bresp_next     = bresp_reg;
        rvalid_next    = rvalid_reg;
        rresp_next     = rresp_reg;
        rdata_next     = rdata_reg;

        case (state_reg)
            IDLE: begin
                if (write_req && read_req) begin
                    prio_rd_next = ~prio_rd_reg;
                end
                if (grant_wr) begin
                    reg_addr_next  = aw_aligned;
                    reg_wdata_next = s_axil_wdata;
                    reg_wen_next   = wr_ok;
                    acc_ok_next    = wr_ok;
                    state_next     = WR_EXEC;
                end else if (grant_rd) begin
                    reg_addr_next = ar_aligned;
                    acc_ok_next   = ar_in_range;
                    state_next    = RD_WAIT;
                end
            end
            WR_EXEC: begin
                reg_wen_next = 1'b0;
                bvalid_next  = 1'b1;
                bresp_next   = acc_ok_reg ? RESP_OKAY : RESP_SLVERR;
                state_next   = WR_RESP;
            end
            WR_RESP: begin
                if (s_axil_bready) begin
                    bvalid_next = 1'b0;
                    state_next  = IDLE;
                end
            end
            RD_WAIT: begin
                // reg_rdata has had a full cycle to settle on the new reg_addr
                rdata_next  = acc_ok_reg ? reg_rdata : 32'd0;
                rresp_next  = acc_ok_reg ? RESP_OKAY : RESP_SLVERR;
                rvalid_next = 1'b1;
                state_next  = RD_RESP;
            end
            RD_RESP: begin
                if (s_axil_rready) begin
                    rvalid_next = 1'b0;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg     <= IDLE;
            prio_rd_reg   <= 1'b0;
            acc_ok_reg    <= 1'b0;
            reg_wen_reg   <= 1'b0;
            reg_addr_reg  <= 32'd0;
            reg_wdata_reg <= 32'd0;
            bvalid_reg    <= 1'b0;
            bresp_reg     <= RESP_OKAY;
            rvalid_reg    <= 1'b0;
            rresp_reg     <= RESP_OKAY;
            rdata_reg     <= 32'd0;
        end else begin
            state_reg     <= state_next;
            prio_rd_reg   <= prio_rd_next;
            acc_ok_reg    <= acc_ok_next;
            reg_wen_reg   <= reg_wen_next;
            reg_addr_reg  <= reg_addr_next;
            reg_wdata_reg <= reg_wdata_next;
            bvalid_reg    <= bvalid_next;
            bresp_reg     <= bresp_next;
            rvalid_reg    <= rvalid_next;
            rresp_reg     <= rresp_next;
            rdata_reg     <= rdata_next;
        end
    end

    assign reg_wen       = reg_wen_reg;
    assign reg_addr      = reg_addr_reg;
    assign reg_wdata     = reg_wdata_reg;
    assign s_axil_bvalid = bvalid_reg;
    assign s_axil_bresp  = bresp_reg;
    assign s_axil_rvalid = rvalid_reg;
    assign s_axil_rresp  = rresp_reg;
    assign s_axil_rdata  = rdata_reg;

endmodule

// File: doc/axil_reg_bridge.md
Name: axil_reg_bridge

Overview:
- AXI4-Lite slave that acts as the initiator of the simple register bus (wen/addr/wdata/rdata) used by the design's register-logic blocks.
- Converts each AXI4-Lite write or read into one register-bus access and returns the AXI response.
- Sits between the host AXI interconnect and one register-logic block in the same clock domain.
- One transaction in flight at a time.

Parameters:
- AXI_ADDR_W, 32, width of the AXI address ports; the value is zero-extended onto the 32-bit reg_addr.
- MAX_ADDR, 32'h40, highest valid register byte address; used only when the optional feature is compiled in.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axil_awaddr  in  AXI_ADDR_W  write address
- s_axil_awvalid  in  1  write address valid
- s_axil_awready  out  1  write address ready
- s_axil_wdata  in  32  write data
- s_axil_wstrb  in  4  write byte strobes
- s_axil_wvalid  in  1  write data valid
- s_axil_wready  out  1  write data ready
- s_axil_bresp  out  2  write response
- s_axil_bvalid  out  1  write response valid
- s_axil_bready  in  1  write response ready
- s_axil_araddr  in  AXI_ADDR_W  read address
- s_axil_arvalid  in  1  read address valid
- s_axil_arready  out  1  read address ready
- s_axil_rdata  out  32  read data
- s_axil_rresp  out  2  read response
- s_axil_rvalid  out  1  read valid
- s_axil_rready  in  1  read ready
- reg_wen  out  1  register write strobe, single-cycle pulse
- reg_addr  out  32  register byte address
- reg_wdata  out  32  register write data
- reg_rdata  in  32  combinational read data for reg_addr

Behaviour:
- Single clock aclk. aresetn is asynchronous, active-low.
- Reset values: state IDLE, reg_wen=0, reg_addr=0, reg_wdata=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, priority flag = write-first.
- FSM states: IDLE, WR_EXEC, WR_RESP, RD_WAIT, RD_RESP.
- IDLE:
  - write_req = awvalid & wvalid. read_req = arvalid.
  - If only one request is present, grant it.
  - If both are present, grant according to the priority flag; the flag toggles after every grant made while both requests were present (round-robin).
- awready, wready, arready are combinational and high only in IDLE on the granted request's cycle. AW and W are always accepted in the same cycle.
- Write sequence:
  - Handshake edge: reg_addr <= {awaddr[31:2],2'b00}, reg_wdata <= wdata, reg_wen <= (wstrb==4'hF); go to WR_EXEC.
  - WR_EXEC (1 cycle): on the next edge reg_wen <= 0, bvalid <= 1, bresp <= (wstrb==4'hF) ? OKAY : SLVERR; go to WR_RESP.
  - Partial strobes therefore produce no write and return SLVERR.
- WR_RESP: hold bvalid and bresp until bready is sampled high, then bvalid <= 0 and go to IDLE.
- Read sequence:
  - Handshake edge: reg_addr <= {araddr[31:2],2'b00}; go to RD_WAIT.
  - RD_WAIT: one settle cycle, then s_axil_rdata <= reg_rdata, rresp <= OKAY, rvalid <= 1; go to RD_RESP.
  - RD_RESP: hold rvalid, rdata, rresp until rready, then go to IDLE.
- Latency:
  - Write: reg_wen asserted 1 cycle after the AW/W handshake; bvalid 2 cycles after the handshake.
  - Read: rvalid 2 cycles after the AR handshake.
- Minimum idle-to-idle time per transaction: 3 cycles with ready/bready held high.
- reg_addr and reg_wdata hold their last values in IDLE. Reads never pulse reg_wen.
- No new AW, W or AR handshake is accepted outside IDLE, regardless of valids.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronous). Any pending response is dropped and any reg_wen pulse is cut.
- Address bits [1:0] are ignored. Addresses wider than 32 bits are truncated to 32.

Optional Feature:
- Macro: AXIL_REG_BRIDGE_ADDR_CHECK_EN.
- When defined, an access whose aligned address is greater than MAX_ADDR:
  - Write: reg_wen is never asserted; bresp = SLVERR.
  - Read: reg_addr is still driven; rdata = 0; rresp = SLVERR.
  - Response timing is unchanged.
- When undefined, no range check is made and every full-strobe access returns OKAY.

Test Plan:
- Write awaddr=0x10, wdata=0x0000ABCD, wstrb=0xF -> exactly one reg_wen pulse with reg_addr=0x10 and reg_wdata=0xABCD, then bresp=0 with bvalid held until bready.
- Read araddr=0x2E while the model returns 0x00000005 for address 0x2C -> reg_addr=0x2C, rdata=0x5, rresp=0, rvalid 2 cycles after the handshake.
- AW+W and AR valid simultaneously from reset, twice in a row -> first pair: write served first, then read; second pair: read served first; no reg_wen during the reads.
- Write with wstrb=0x3 -> no reg_wen, bresp=2. Hold bready low for 10 cycles -> bvalid stays high and arready stays low throughout.
- Assert aresetn low during RD_WAIT -> rvalid=0, state IDLE, outputs at reset values; a following read of 0x04 completes normally.
- With AXIL_REG_BRIDGE_ADDR_CHECK_EN and MAX_ADDR=0x40: write to 0x44 -> no reg_wen, bresp=2; read of 0x44 -> rdata=0, rresp=2; access to 0x40 -> OKAY.
